// File: rtl/reg_file_sb.sv
// Register file for the ID stage with write-through forwarding and a per-register
// pending-write scoreboard that drives rd_busy / iss_ok for the hazard unit.
module reg_file_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 4,
    parameter int NUM_REGS = 15,
    parameter int NUM_RD   = 2,
    parameter int PEND_W   = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
    output logic [NUM_RD*DATA_W-1:0]   rd_data,
    output logic [NUM_RD-1:0]          rd_busy,
    input  logic                       iss_en,
    input  logic [ADDR_W-1:0]          iss_dst,
    output logic                       iss_ok,
    input  logic                       wb_en,
    input  logic [ADDR_W-1:0]          wb_dst,
    input  logic [DATA_W-1:0]          wb_val,
    input  logic                       flush,
    output logic                       err
);

    localparam logic [ADDR_W:0]   REG_LIMIT = (ADDR_W+1)'(NUM_REGS);
    localparam logic [PEND_W-1:0] CNT_MAX   = '1;
    localparam logic [PEND_W-1:0] CNT_ONE   = PEND_W'(1);

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic [PEND_W-1:0] cnt  [NUM_REGS];

    logic              iss_in;
    logic              wb_in;
    logic              iss_acc;
    logic              wb_dec;
    logic              same_dst;
    logic [PEND_W-1:0] iss_cnt;
    logic [PEND_W-1:0] wb_cnt;

    // Out-of-range destinations see a zero count, so they never saturate or decrement.
    assign iss_in   = {1'b0, iss_dst} < REG_LIMIT;
    assign wb_in    = wb_en && ({1'b0, wb_dst} < REG_LIMIT);
    assign iss_cnt  = iss_in ? cnt[iss_dst] : '0;
    assign wb_cnt   = wb_in ? cnt[wb_dst] : '0;
    assign iss_ok   = (iss_cnt != CNT_MAX);
    assign iss_acc  = iss_en && iss_in && iss_ok;
    assign wb_dec   = wb_in && (wb_cnt != '0);
    assign same_dst = iss_en && wb_en && (iss_dst == wb_dst);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= DATA_W'(i);
            end
        end else if (wb_in) begin
            regs[wb_dst] <= wb_val;
        end
    end

    // A matched issue/write-back pair cancels out, leaving the count untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst || flush) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                cnt[i] <= '0;
            end
        end else if (!same_dst) begin
            if (iss_acc) begin
                cnt[iss_dst] <= iss_cnt + CNT_ONE;
            end
            if (wb_dec) begin
                cnt[wb_dst] <= wb_cnt - CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err <= 1'b0;
        end else if ((iss_en && !iss_ok) || (wb_in && (wb_cnt == '0) && !flush)) begin
            err <= 1'b1;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] a;
        logic              in_range;
        logic              hit;

        assign a        = rd_addr[k*ADDR_W +: ADDR_W];
        assign in_range = {1'b0, a} < REG_LIMIT;
        assign hit      = wb_en && (wb_dst == a);

        // A same-cycle write-back retires one pending write before busy is judged.
        assign rd_data[k*DATA_W +: DATA_W] = !in_range ? '0 : (hit ? wb_val : regs[a]);
        assign rd_busy[k] = in_range && (hit ? (cnt[a] > CNT_ONE) : (cnt[a] != '0));
    end

endmodule
